orao_tape_player: RTL and testbench

//  Cassette-input stage that sits between the ioctl tape download and orao_io. It thresholds downloaded audio bytes to 1-bit samples.

---
 rtl/orao_pkg.sv | 14 +
 rtl/tape_bit_fifo.sv | 61 ++++++
 rtl/orao_tape_player.sv | 142 ++++++++++++++
 tb/tb_orao_tape_player.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/orao_pkg.sv
// Shared types and constants for the Orao cassette-input stage.
package orao_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        PLAY  = 3'd2,
        DRAIN = 3'd3
    } tape_state_t;

    // CPU address of the tape input port read by orao_io.
    localparam logic [15:0] TAPE_PORT_ADDR = 16'h87FF;

endpackage

// File: rtl/tape_bit_fifo.sv
// One-bit-wide sample FIFO. Push into a full FIFO and pop from an empty one are
// ignored here; the parent decides what those events mean. Flush wins over push/pop.
module tape_bit_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic        din,
    output logic        dout,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Head of queue is presented combinationally; the parent registers it on a pop.
    assign dout = mem[rd_ptr_reg];

    // Sample storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count      <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count      <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/orao_tape_player.sv
// Cassette-input stage: thresholds downloaded audio bytes into 1-bit samples,
// buffers them, and hands one sample to the CPU per group of tape-port reads.
module orao_tape_player
    import orao_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [7:0]  TAPE_INDEX    = 8'h01,
    parameter logic [7:0]  THRESHOLD     = 8'h80,
    parameter int          READS_PER_SMP = 2,
    parameter int          TIMEOUT_CYC   = 75_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [7:0]  tape_data,
    output logic        tape_active,
    output logic        tape_underrun,
    output logic        tape_overflow
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     HALF_LVL = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [AW:0]     WAIT_LVL = (AW+1)'(FIFO_DEPTH - 2);
    localparam logic [3:0]      RD_LAST  = 4'(READS_PER_SMP - 1);
    localparam logic [26:0]     TO_LIMIT = 27'(TIMEOUT_CYC);

    tape_state_t state_reg, state_next;
    logic        sel_reg;
    logic [15:0] prev_addr_reg;
    logic [3:0]  rd_cnt_reg;
    logic [26:0] to_cnt_reg;

    logic        sel_dl, rise, fall, read_evt, timeout_hit, normal, playing;
    logic        wr_attempt, push_req, pop_req, flush, push_ok, pop_ok;
    logic        fifo_dout, fifo_full, fifo_empty;
    logic [AW:0] count, count_next;

    assign sel_dl      = ioctl_download && (ioctl_index == TAPE_INDEX);
    assign rise        = sel_dl && !sel_reg;
    assign fall        = !sel_dl && sel_reg;
    assign read_evt    = ce && (cpu_addr == TAPE_PORT_ADDR) && (prev_addr_reg != TAPE_PORT_ADDR);
    assign timeout_hit = (state_reg != IDLE) && (to_cnt_reg >= TO_LIMIT);
    // A download restart beats a timeout abort, which beats ordinary traffic.
    assign normal      = !rise && !timeout_hit;
    assign playing     = (state_reg == PLAY) || (state_reg == DRAIN);
    assign wr_attempt  = ioctl_wr && sel_dl && (state_reg != IDLE);
    assign push_req    = normal && wr_attempt;
    // Read events only advance playback once the CPU is being fed (PLAY/DRAIN).
    assign pop_req     = normal && playing && read_evt && (rd_cnt_reg == RD_LAST);
    assign flush       = rise || timeout_hit;
    assign push_ok     = push_req && !fifo_full;
    assign pop_ok      = pop_req && !fifo_empty;

    tape_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .pop     (pop_req),
        .flush   (flush),
        .din     (ioctl_dout >= THRESHOLD),
        .dout    (fifo_dout),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Occupancy after this edge, so registered outputs line up with the FIFO.
    always_comb begin
        count_next = count;
        if (flush)                  count_next = '0;
        else if (push_ok && !pop_ok) count_next = count + 1'b1;
        else if (pop_ok && !push_ok) count_next = count - 1'b1;
    end

    // Next playback state.
    always_comb begin
        state_next = state_reg;
        if (rise) begin
            state_next = FILL;
        end else if (timeout_hit) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                FILL:    if (fall || count >= HALF_LVL) state_next = PLAY;
                PLAY:    if (fall) state_next = DRAIN;
                DRAIN:   if (pop_req && count_next == '0) state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    // State, edge history, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            sel_reg       <= 1'b1;  // forces a fresh download edge after reset
            prev_addr_reg <= '0;
            rd_cnt_reg    <= '0;
            to_cnt_reg    <= '0;
            ioctl_wait    <= 1'b0;
            tape_data     <= 8'h00;
            tape_active   <= 1'b0;
            tape_underrun <= 1'b0;
            tape_overflow <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_dl;
            if (ce) prev_addr_reg <= cpu_addr;

            tape_active <= (state_next != IDLE);
            // Two slots of headroom absorb a write already in flight when wait rises.
            ioctl_wait  <= (state_next != IDLE) && (count_next >= WAIT_LVL);

            if (rise || read_evt || wr_attempt) to_cnt_reg <= '0;
            else if (to_cnt_reg != '1)          to_cnt_reg <= to_cnt_reg + 1'b1;

            if (flush) begin
                rd_cnt_reg <= '0;
            end else if (playing && read_evt) begin
                rd_cnt_reg <= (rd_cnt_reg == RD_LAST) ? 4'd0 : rd_cnt_reg + 4'd1;
            end

            if (rise) begin
                tape_underrun <= 1'b0;
                tape_overflow <= 1'b0;
            end else if (normal) begin
                if (push_req && fifo_full)  tape_overflow <= 1'b1;
                if (pop_req && fifo_empty)  tape_underrun <= 1'b1;
            end

            if (!rise && timeout_hit) tape_data <= 8'h00;
            else if (pop_ok)          tape_data <= {8{fifo_dout}};
        end
    end

endmodule

// File: tb/tb_orao_tape_player.sv
// Bench for orao_tape_player: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_orao_tape_player;

    localparam int DEPTH = 16;
    localparam int TO    = 100;
    localparam int R     = 2;

    logic        clk = 1'b0;
    logic        reset_n, ce, ioctl_download, ioctl_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic        ioctl_wait, tape_active, tape_underrun, tape_overflow;
    logic [7:0]  tape_data;

    always #5 clk = ~clk;

    orao_tape_player #(
        .FIFO_DEPTH    (DEPTH),
        .TAPE_INDEX    (8'h01),
        .THRESHOLD     (8'h80),
        .READS_PER_SMP (R),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ce             (ce),
        .cpu_addr       (cpu_addr),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .tape_data      (tape_data),
        .tape_active    (tape_active),
        .tape_underrun  (tape_underrun),
        .tape_overflow  (tape_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int MI = 0, MF = 1, MP = 2, MD = 3;
    bit          mq[$];
    int          m_mode, m_reads, m_idle;
    bit          m_sel_prev;
    logic [15:0] m_prev;
    logic [7:0]  m_data;
    bit          m_wait, m_active, m_under, m_over;

    always @(posedge clk) begin : model
        bit sel, rise, fall, rd, wr_try, pop_try, playing;
        int n0;
        if (!reset_n) begin
            mq.delete();
            m_mode = MI; m_reads = 0; m_idle = 0; m_sel_prev = 1'b1;
            m_prev = '0; m_data = 8'h00; m_under = 0; m_over = 0;
        end else begin
            sel     = ioctl_download && (ioctl_index == 8'h01);
            rise    = sel && !m_sel_prev;
            fall    = !sel && m_sel_prev;
            rd      = ce && (cpu_addr == 16'h87FF) && (m_prev != 16'h87FF);
            wr_try  = ioctl_wr && sel && (m_mode != MI);
            playing = (m_mode == MP) || (m_mode == MD);
            n0      = mq.size();
            if (rise) begin
                mq.delete(); m_reads = 0; m_under = 0; m_over = 0; m_mode = MF;
            end else if (m_mode != MI && m_idle >= TO) begin
                mq.delete(); m_data = 8'h00; m_reads = 0; m_mode = MI;
            end else begin
                pop_try = playing && rd && (m_reads == R - 1);
                if (playing && rd) m_reads = (m_reads + 1) % R;
                if (pop_try) begin
                    if (n0 > 0) m_data = mq.pop_front() ? 8'hFF : 8'h00;
                    else        m_under = 1;
                end
                if (wr_try) begin
                    if (n0 < DEPTH) mq.push_back(ioctl_dout >= 8'h80);
                    else            m_over = 1;
                end
                case (m_mode)
                    MF: if (fall || n0 >= DEPTH / 2) m_mode = MP;
                    MP: if (fall) m_mode = MD;
                    MD: if (pop_try && mq.size() == 0) m_mode = MI;
                    default: ;
                endcase
            end
            if (rise || rd || wr_try) m_idle = 0;
            else if (m_idle < (1 << 27) - 1) m_idle = m_idle + 1;
            if (ce) m_prev = cpu_addr;
            m_sel_prev = sel;
        end
        m_active = (m_mode != MI);
        m_wait   = m_active && (mq.size() >= DEPTH - 2);
        #2;
        check("m_wait",     {7'b0, ioctl_wait},    {7'b0, m_wait});
        check("m_data",     tape_data,             m_data);
        check("m_active",   {7'b0, tape_active},   {7'b0, m_active});
        check("m_underrun", {7'b0, tape_underrun}, {7'b0, m_under});
        check("m_overflow", {7'b0, tape_overflow}, {7'b0, m_over});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        ioctl_wr = 1'b1; ioctl_dout = b;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_event();
        ce = 1'b1; cpu_addr = 16'h0000;
        @(negedge clk);
        cpu_addr = 16'h87FF;
        @(negedge clk);
        ce = 1'b0; cpu_addr = 16'h0000;
        @(negedge clk);
    endtask

    task automatic rd_pair();
        rd_event();
        rd_event();
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b0; cpu_addr = '0; ioctl_download = 1'b0;
        ioctl_index = 8'h01; ioctl_wr = 1'b0; ioctl_dout = '0;
        tick(3);
        check("rst_wait",   {7'b0, ioctl_wait},  8'h00);
        check("rst_data",   tape_data,           8'h00);
        check("rst_active", {7'b0, tape_active}, 8'h00);
        reset_n = 1'b1;
        tick(2);

        // Fill to half depth, then PLAY; two reads per sample.
        ioctl_download = 1'b1;
        tick(1);
        check("fill_active", {7'b0, tape_active}, 8'h01);
        for (int k = 0; k < 2; k++) begin
            wr_byte(8'h10); wr_byte(8'hF0); wr_byte(8'h7F); wr_byte(8'h80);
        end
        rd_pair(); check("play_s0", tape_data, 8'h00);
        rd_pair(); check("play_s1", tape_data, 8'hFF);
        rd_pair(); check("play_s2", tape_data, 8'h00);
        rd_pair(); check("play_s3", tape_data, 8'hFF);

        // Host runs ahead: wait at 14, overflow on the 17th entry.
        for (int k = 0; k < 9; k++) wr_byte((k % 2 == 0) ? 8'hF0 : 8'h10);
        check("wait_at13", {7'b0, ioctl_wait}, 8'h00);
        wr_byte(8'hF0);
        check("wait_at14", {7'b0, ioctl_wait}, 8'h01);
        wr_byte(8'h10); wr_byte(8'hF0);
        check("ovf_at16", {7'b0, tape_overflow}, 8'h00);
        wr_byte(8'hF0);
        check("ovf_at17", {7'b0, tape_overflow}, 8'h01);

        // Drain: 11 pops leave 5, download ends, 5 more pops empty it.
        repeat (11) rd_pair();
        ioctl_download = 1'b0;
        tick(2);
        check("drain_active", {7'b0, tape_active}, 8'h01);
        repeat (5) rd_pair();
        check("drain_idle",  {7'b0, tape_active},   8'h00);
        check("drain_under", {7'b0, tape_underrun}, 8'h00);
        rd_pair();
        check("idle_under", {7'b0, tape_underrun}, 8'h00);
        check("ovf_sticky", {7'b0, tape_overflow}, 8'h01);

        // Timeout while playing.
        ioctl_download = 1'b1;
        tick(1);
        check("rise_clr_ovf", {7'b0, tape_overflow}, 8'h00);
        repeat (8) wr_byte(8'hF0);
        rd_pair();
        check("to_pre_data", tape_data, 8'hFF);
        tick(110);
        check("to_active", {7'b0, tape_active}, 8'h00);
        check("to_wait",   {7'b0, ioctl_wait},  8'h00);
        check("to_data",   tape_data,           8'h00);

        // Simultaneous push and pop at count 3.
        ioctl_download = 1'b0; tick(2);
        ioctl_download = 1'b1; tick(1);
        repeat (4) begin wr_byte(8'h10); wr_byte(8'hF0); end
        repeat (5) rd_pair();
        check("pp_pre", tape_data, 8'h00);
        rd_event();
        ce = 1'b1; cpu_addr = 16'h0000;
        @(negedge clk);
        cpu_addr = 16'h87FF; ioctl_wr = 1'b1; ioctl_dout = 8'hFF;
        @(negedge clk);
        ce = 1'b0; cpu_addr = 16'h0000; ioctl_wr = 1'b0;
        @(negedge clk);
        check("pp_pop", tape_data, 8'hFF);
        rd_pair(); check("pp_s0", tape_data, 8'h00);
        rd_pair(); check("pp_s1", tape_data, 8'hFF);
        rd_pair(); check("pp_s2", tape_data, 8'hFF);
        check("pp_no_under", {7'b0, tape_underrun}, 8'h00);
        rd_pair();
        check("pp_under", {7'b0, tape_underrun}, 8'h01);
        check("pp_hold",  tape_data,             8'hFF);

        // Reset mid-download, then no restart without a fresh edge.
        ioctl_download = 1'b0; tick(2);
        ioctl_download = 1'b1; tick(1);
        repeat (14) wr_byte(8'h80);
        check("pre_rst_wait", {7'b0, ioctl_wait}, 8'h01);
        reset_n = 1'b0;
        tick(1);
        check("mid_rst_wait",   {7'b0, ioctl_wait},  8'h00);
        check("mid_rst_data",   tape_data,           8'h00);
        check("mid_rst_active", {7'b0, tape_active}, 8'h00);
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("post_rst_idle", {7'b0, tape_active}, 8'h00);
        wr_byte(8'h80); wr_byte(8'h80);
        check("post_rst_nowr", {7'b0, tape_active}, 8'h00);

        // Foreign download index is ignored.
        ioctl_download = 1'b0; tick(1);
        ioctl_index = 8'h00; ioctl_download = 1'b1; tick(1);
        repeat (4) wr_byte(8'hFF);
        check("idx0_active", {7'b0, tape_active}, 8'h00);
        ioctl_index = 8'h01;
        tick(1);
        check("idx1_active", {7'b0, tape_active}, 8'h01);

        // Randomized soak with periodic quiet stretches to exercise the timeout.
        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 1000; c++) begin
                int sel;
                ce       = 1'($urandom_range(0, 1));
                sel      = int'($urandom_range(0, 3));
                cpu_addr = (sel == 0) ? 16'h87FF : (sel == 1) ? 16'h0000 : 16'($urandom);
                ioctl_wr   = ($urandom_range(0, 2) == 0);
                ioctl_dout = 8'($urandom);
                if ($urandom_range(0, 149) == 0) ioctl_download = !ioctl_download;
                ioctl_index = ($urandom_range(0, 39) == 0) ? 8'h00 : 8'h01;
                reset_n     = ($urandom_range(0, 699) != 0);
                @(negedge clk);
            end
            reset_n = 1'b1; ce = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'h01;
            tick(120);
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
